au_issue_arbiter: RTL and testbench

// Schedules address-calculation requests from the load and store reservation stations onto the

---
 rtl/viola_ls_pkg.sv | 32 +++
 rtl/au_req_fifo.sv | 81 ++++++++
 rtl/au_issue_arbiter.sv | 157 +++++++++++++++
 tb/tb_au_issue_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viola_ls_pkg.sv
// Shared types and constants for the load/store address-unit issue path.
package viola_ls_pkg;

  localparam int XLEN  = 32;
  localparam int ROB_W = 3;
  localparam int OP_W  = 5;

  localparam logic [OP_W-1:0] OP_NOP = 5'b11111;

  // One buffered address-calculation request (data is only meaningful for stores)
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  offset;
    logic [XLEN-1:0]  data;
  } ls_req_t;

  // Which FIFO head the arbiter picked this cycle
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_LOAD  = 2'd1,
    SEL_STORE = 2'd2
  } sel_e;

  // Distance of a ROB tag from the current head; smaller means older
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                               input logic [ROB_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/au_req_fifo.sv
// Small request FIFO, one per requester, with synchronous flush.
module au_req_fifo
  import viola_ls_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  logic    pop_i,
  input  logic    flush_i,
  input  ls_req_t data_i,
  output ls_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ls_req_t          mem_q [DEPTH];

  logic doPush;
  logic doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

  // A full FIFO refuses pushes even when it is popped in the same cycle
  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Next pointer/count state; flush empties the FIFO and wins over push/pop
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage write; entries are only read once the count says they are valid
  always_ff @(posedge clk) begin
    if (rst && doPush && !flush_i) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/au_issue_arbiter.sv
// Oldest-first arbiter issuing buffered load/store requests onto the shared address unit.
module au_issue_arbiter
  import viola_ls_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause_i,
  input  logic             flush_i,
  input  logic [ROB_W-1:0] rob_head_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  input  logic [OP_W-1:0]  ld_op_i,
  input  logic [ROB_W-1:0] ld_rob_i,
  input  logic [XLEN-1:0]  ld_base_i,
  input  logic [XLEN-1:0]  ld_offset_i,
  input  logic             st_valid_i,
  output logic             st_ready_o,
  input  logic [OP_W-1:0]  st_op_i,
  input  logic [ROB_W-1:0] st_rob_i,
  input  logic [XLEN-1:0]  st_base_i,
  input  logic [XLEN-1:0]  st_offset_i,
  input  logic [XLEN-1:0]  st_data_i,
  output logic [XLEN-1:0]  au_value1_o,
  output logic [XLEN-1:0]  au_value2_o,
  output logic [OP_W-1:0]  au_op_o,
  output logic [ROB_W-1:0] au_rob_o,
  output logic [XLEN-1:0]  au_ls_value_o,
  output logic             busy_o
);

  ls_req_t ldIn, stIn;
  ls_req_t ldHead, stHead;
  logic    ldFull, ldEmpty, stFull, stEmpty;
  logic    ldPop, stPop;
  logic    issueEn;
  sel_e    sel;

  logic [ROB_W-1:0] ldAge, stAge;

  logic [XLEN-1:0]  auValue1_q, auValue1_d;
  logic [XLEN-1:0]  auValue2_q, auValue2_d;
  logic [OP_W-1:0]  auOp_q, auOp_d;
  logic [ROB_W-1:0] auRob_q, auRob_d;
  logic [XLEN-1:0]  auLsValue_q, auLsValue_d;

  assign ldIn = '{op: ld_op_i, rob: ld_rob_i, base: ld_base_i, offset: ld_offset_i, data: '0};
  assign stIn = '{op: st_op_i, rob: st_rob_i, base: st_base_i, offset: st_offset_i,
                  data: st_data_i};

  au_req_fifo #(.DEPTH(DEPTH)) uLdFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ld_valid_i),
    .pop_i   (ldPop),
    .flush_i (flush_i),
    .data_i  (ldIn),
    .head_o  (ldHead),
    .full_o  (ldFull),
    .empty_o (ldEmpty)
  );

  au_req_fifo #(.DEPTH(DEPTH)) uStFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (st_valid_i),
    .pop_i   (stPop),
    .flush_i (flush_i),
    .data_i  (stIn),
    .head_o  (stHead),
    .full_o  (stFull),
    .empty_o (stEmpty)
  );

  assign ld_ready_o = !ldFull;
  assign st_ready_o = !stFull;

  assign ldAge = rob_age(ldHead.rob, rob_head_i);
  assign stAge = rob_age(stHead.rob, rob_head_i);

  // Pick the older FIFO head; a tie goes to the store
  always_comb begin
    sel = SEL_NONE;
    if (!ldEmpty && !stEmpty) begin
      sel = (ldAge < stAge) ? SEL_LOAD : SEL_STORE;
    end else if (!ldEmpty) begin
      sel = SEL_LOAD;
    end else if (!stEmpty) begin
      sel = SEL_STORE;
    end
  end

  assign issueEn = !pause_i && !flush_i;
  assign ldPop   = issueEn && (sel == SEL_LOAD);
  assign stPop   = issueEn && (sel == SEL_STORE);

  // Issue stage next state: load the selected head, or drop to NOP keeping operands
  always_comb begin
    auValue1_d  = auValue1_q;
    auValue2_d  = auValue2_q;
    auOp_d      = auOp_q;
    auRob_d     = auRob_q;
    auLsValue_d = auLsValue_q;
    if (flush_i) begin
      auOp_d  = OP_NOP;
      auRob_d = '0;
    end else if (!pause_i) begin
      case (sel)
        SEL_LOAD: begin
          auValue1_d  = ldHead.base;
          auValue2_d  = ldHead.offset;
          auOp_d      = ldHead.op;
          auRob_d     = ldHead.rob;
          auLsValue_d = '0;
        end
        SEL_STORE: begin
          auValue1_d  = stHead.base;
          auValue2_d  = stHead.offset;
          auOp_d      = stHead.op;
          auRob_d     = stHead.rob;
          auLsValue_d = stHead.data;
        end
        default: begin
          auOp_d  = OP_NOP;
          auRob_d = '0;
        end
      endcase
    end
  end

  // Registered AU interface with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      auValue1_q  <= '0;
      auValue2_q  <= '0;
      auOp_q      <= OP_NOP;
      auRob_q     <= '0;
      auLsValue_q <= '0;
    end else begin
      auValue1_q  <= auValue1_d;
      auValue2_q  <= auValue2_d;
      auOp_q      <= auOp_d;
      auRob_q     <= auRob_d;
      auLsValue_q <= auLsValue_d;
    end
  end

  assign au_value1_o   = auValue1_q;
  assign au_value2_o   = auValue2_q;
  assign au_op_o       = auOp_q;
  assign au_rob_o      = auRob_q;
  assign au_ls_value_o = auLsValue_q;

  assign busy_o = !ldEmpty || !stEmpty || (auOp_q != OP_NOP);

endmodule

// File: tb/tb_au_issue_arbiter.sv
// Directed self-checking bench for the AU issue arbiter.
module tb_au_issue_arbiter;
  import viola_ls_pkg::*;

  logic             clk;
  logic             rst;
  logic             pause;
  logic             flush;
  logic [ROB_W-1:0] robHead;
  logic             ldValid, ldReady;
  logic [OP_W-1:0]  ldOp;
  logic [ROB_W-1:0] ldRob;
  logic [XLEN-1:0]  ldBase, ldOffset;
  logic             stValid, stReady;
  logic [OP_W-1:0]  stOp;
  logic [ROB_W-1:0] stRob;
  logic [XLEN-1:0]  stBase, stOffset, stData;
  logic [XLEN-1:0]  auValue1, auValue2, auLsValue;
  logic [OP_W-1:0]  auOp;
  logic [ROB_W-1:0] auRob;
  logic             busy;

  int checks = 0;
  int errors = 0;

  au_issue_arbiter #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pause_i       (pause),
    .flush_i       (flush),
    .rob_head_i    (robHead),
    .ld_valid_i    (ldValid),
    .ld_ready_o    (ldReady),
    .ld_op_i       (ldOp),
    .ld_rob_i      (ldRob),
    .ld_base_i     (ldBase),
    .ld_offset_i   (ldOffset),
    .st_valid_i    (stValid),
    .st_ready_o    (stReady),
    .st_op_i       (stOp),
    .st_rob_i      (stRob),
    .st_base_i     (stBase),
    .st_offset_i   (stOffset),
    .st_data_i     (stData),
    .au_value1_o   (auValue1),
    .au_value2_o   (auValue2),
    .au_op_o       (auOp),
    .au_rob_o      (auRob),
    .au_ls_value_o (auLsValue),
    .busy_o        (busy)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence never reaches its end
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance the given number of clock edges; outputs are sampled 1 unit after the edge
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setLoad(input logic v, input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                         input logic [XLEN-1:0] base, input logic [XLEN-1:0] off);
    ldValid  = v;
    ldOp     = op;
    ldRob    = rob;
    ldBase   = base;
    ldOffset = off;
  endtask

  task automatic setStore(input logic v, input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                          input logic [XLEN-1:0] base, input logic [XLEN-1:0] off,
                          input logic [XLEN-1:0] data);
    stValid  = v;
    stOp     = op;
    stRob    = rob;
    stBase   = base;
    stOffset = off;
    stData   = data;
  endtask

  initial begin
    rst     = 1'b0;
    pause   = 1'b0;
    flush   = 1'b0;
    robHead = 3'd0;
    setLoad(1'b0, 5'h0, 3'd0, 32'h0, 32'h0);
    setStore(1'b0, 5'h0, 3'd0, 32'h0, 32'h0, 32'h0);

    // Reset held for two edges
    applyStimulus(2);
    rst = 1'b1;
    checkOutput("reset_au_op", 32'(auOp), 32'h1F);
    checkOutput("reset_au_rob", 32'(auRob), 32'h0);
    checkOutput("reset_au_value1", auValue1, 32'h0);
    checkOutput("reset_au_ls_value", auLsValue, 32'h0);
    checkOutput("reset_ld_ready", 32'(ldReady), 32'h1);
    checkOutput("reset_st_ready", 32'(stReady), 32'h1);
    checkOutput("reset_busy", 32'(busy), 32'h0);

    // Single load: enqueued on one edge, issued on the next
    setLoad(1'b1, 5'h01, 3'd2, 32'h100, 32'h4);
    applyStimulus(1);
    ldValid = 1'b0;
    checkOutput("load_no_bypass_op", 32'(auOp), 32'h1F);
    checkOutput("load_queued_busy", 32'(busy), 32'h1);
    applyStimulus(1);
    checkOutput("load_issue_value1", auValue1, 32'h100);
    checkOutput("load_issue_value2", auValue2, 32'h4);
    checkOutput("load_issue_rob", 32'(auRob), 32'h2);
    checkOutput("load_issue_op", 32'(auOp), 32'h01);
    checkOutput("load_issue_ls_value", auLsValue, 32'h0);
    applyStimulus(1);
    checkOutput("load_after_op", 32'(auOp), 32'h1F);
    checkOutput("load_after_rob", 32'(auRob), 32'h0);
    checkOutput("load_after_value1_hold", auValue1, 32'h100);
    checkOutput("load_after_busy", 32'(busy), 32'h0);

    // Age ordering with wrap: head=6, store rob 7 (age 1) beats load rob 1 (age 3)
    robHead = 3'd6;
    setLoad(1'b1, 5'h02, 3'd1, 32'h200, 32'h8);
    setStore(1'b1, 5'h03, 3'd7, 32'h300, 32'hC, 32'h55);
    applyStimulus(1);
    ldValid = 1'b0;
    stValid = 1'b0;
    applyStimulus(1);
    checkOutput("age_first_rob", 32'(auRob), 32'h7);
    checkOutput("age_first_op", 32'(auOp), 32'h03);
    checkOutput("age_first_ls_value", auLsValue, 32'h55);
    applyStimulus(1);
    checkOutput("age_second_rob", 32'(auRob), 32'h1);
    checkOutput("age_second_op", 32'(auOp), 32'h02);
    checkOutput("age_second_ls_value", auLsValue, 32'h0);
    applyStimulus(1);
    checkOutput("age_idle_op", 32'(auOp), 32'h1F);

    // Equal ages: store wins the tie
    robHead = 3'd0;
    setLoad(1'b1, 5'h04, 3'd3, 32'h600, 32'h1);
    setStore(1'b1, 5'h05, 3'd3, 32'h700, 32'h2, 32'h77);
    applyStimulus(1);
    ldValid = 1'b0;
    stValid = 1'b0;
    applyStimulus(1);
    checkOutput("tie_first_op", 32'(auOp), 32'h05);
    applyStimulus(1);
    checkOutput("tie_second_op", 32'(auOp), 32'h04);
    checkOutput("tie_second_value1", auValue1, 32'h600);
    applyStimulus(1);

    // Fill the load FIFO while paused
    pause = 1'b1;
    setLoad(1'b1, 5'h06, 3'd2, 32'h400, 32'h10);
    applyStimulus(1);
    checkOutput("pause_one_ld_ready", 32'(ldReady), 32'h1);
    setLoad(1'b1, 5'h06, 3'd3, 32'h500, 32'h14);
    applyStimulus(1);
    checkOutput("pause_full_ld_ready", 32'(ldReady), 32'h0);
    checkOutput("pause_hold_op", 32'(auOp), 32'h1F);
    checkOutput("pause_hold_value1", auValue1, 32'h600);
    // Release pause while offering another load to the full FIFO: it must be refused
    pause = 1'b0;
    setLoad(1'b1, 5'h06, 3'd7, 32'hBAD, 32'h0);
    applyStimulus(1);
    ldValid = 1'b0;
    checkOutput("release_first_rob", 32'(auRob), 32'h2);
    checkOutput("release_first_value1", auValue1, 32'h400);
    checkOutput("release_ld_ready", 32'(ldReady), 32'h1);
    applyStimulus(1);
    checkOutput("release_second_rob", 32'(auRob), 32'h3);
    checkOutput("release_second_value1", auValue1, 32'h500);
    applyStimulus(1);
    checkOutput("full_no_passthrough_op", 32'(auOp), 32'h1F);
    checkOutput("full_no_passthrough_busy", 32'(busy), 32'h0);

    // Flush with an op staged, three requests queued and pause asserted
    setLoad(1'b1, 5'h07, 3'd5, 32'h800, 32'h0);
    applyStimulus(1);
    ldValid = 1'b0;
    applyStimulus(1);
    checkOutput("preflush_op", 32'(auOp), 32'h07);
    pause = 1'b1;
    setLoad(1'b1, 5'h08, 3'd1, 32'hA00, 32'h0);
    applyStimulus(1);
    setLoad(1'b1, 5'h08, 3'd2, 32'hA10, 32'h0);
    setStore(1'b1, 5'h09, 3'd4, 32'hB00, 32'h0, 32'h1);
    applyStimulus(1);
    stValid = 1'b0;
    checkOutput("preflush_hold_op", 32'(auOp), 32'h07);
    checkOutput("preflush_ld_ready", 32'(ldReady), 32'h0);
    flush = 1'b1;
    setLoad(1'b1, 5'h08, 3'd6, 32'hA20, 32'h0);
    applyStimulus(1);
    checkOutput("flush_op", 32'(auOp), 32'h1F);
    checkOutput("flush_rob", 32'(auRob), 32'h0);
    checkOutput("flush_busy", 32'(busy), 32'h0);
    checkOutput("flush_ld_ready", 32'(ldReady), 32'h1);
    checkOutput("flush_st_ready", 32'(stReady), 32'h1);
    flush = 1'b0;
    pause = 1'b0;
    ldValid = 1'b0;
    applyStimulus(1);
    checkOutput("postflush_op", 32'(auOp), 32'h1F);
    checkOutput("postflush_busy", 32'(busy), 32'h0);

    // Store with data reaches the AU store-value output
    setStore(1'b1, 5'h0A, 3'd4, 32'h900, 32'h20, 32'hDEADBEEF);
    applyStimulus(1);
    stValid = 1'b0;
    applyStimulus(1);
    checkOutput("store_ls_value", auLsValue, 32'hDEADBEEF);
    checkOutput("store_op", 32'(auOp), 32'h0A);
    checkOutput("store_rob", 32'(auRob), 32'h4);
    checkOutput("store_value1", auValue1, 32'h900);
    checkOutput("store_value2", auValue2, 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
